vga_frame_checker: RTL and testbench
====================================

VGA_FRAME_CHECKER -- requirements
Module: vga_frame_checker

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 SHALL have parameter H_SYNC, default 96, hsync low width in clocks.
REQ-003 SHALL have parameter H_ACT_S, default 144, first active h_pos; active h_pos range is H_ACT_S..H_ACT_S+639.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have parameter V_ACT_S, default 35, first active v_pos; active v_pos range is V_ACT_S..V_ACT_S+479.
REQ-006 SHALL have port clk, input, 1 bit, clock; one pixel per clk.
REQ-007 SHALL have port resetn, input, 1 bit, reset; one clock, asynchronous active-low reset.
REQ-008 SHALL have ports hsync and vsync, input, 1 bit each, active-low syncs from the DebugScreenCore top, synchronous to clk.
REQ-009 SHALL have ports R, G and B, input, 4 bits each, pixel colour.
REQ-010 SHALL have port err_clr, input, 1 bit, clears sticky error flags.
REQ-011 SHALL have port locked, output, 1 bit, high while state is LOCKED.
REQ-012 SHALL have port frame_done, output, 1 bit, single-cycle pulse marking a valid completed frame.
REQ-013 SHALL have port frame_sum, output, 16 bits, checksum of the last valid frame.
REQ-014 SHALL have port frame_cnt, output, 16 bits, count of valid frames.
REQ-015 SHALL have ports err_hlen, err_hsync and err_vlen, output, 1 bit each, sticky error flags.

Function
REQ-016 SHALL register hsync and vsync as hs_q and vs_q, reset value 1; fall = q & ~in and rise = ~q & in, evaluated in the same cycle the input is sampled.
REQ-017 SHALL keep h_pos (10 bits): 0 in a hsync-fall cycle, else increment saturating at 1023.
REQ-018 SHALL keep v_pos (10 bits): 0 in a vsync-fall cycle, else +1 on each hsync fall, saturating at 1023.
REQ-019 SHALL keep line_cnt, which counts hsync falls strictly after the previous vsync fall, including a fall coincident with the current vsync fall.
REQ-020 SHALL treat a pixel as active when h_pos and v_pos are both within their active ranges.
REQ-021 SHALL accumulate, when active, acc = acc + zero-extend({R,G,B}) modulo 2^16.
REQ-022 SHALL implement FSM states SEARCH (reset state) and LOCKED.
REQ-023 SHALL, in SEARCH, perform no checks and no accumulation; a vsync fall moves to LOCKED and clears acc and line_cnt with no frame_done.
REQ-024 SHALL, in LOCKED on hsync fall, set err_hlen and go to SEARCH when the previous h_pos != H_TOTAL-1; the first hsync fall after lock is exempt.
REQ-025 SHALL, in LOCKED on hsync rise, set err_hsync and go to SEARCH when h_pos != H_SYNC.
REQ-026 SHALL, in LOCKED on vsync fall with line_cnt == V_TOTAL, register frame_done=1 for the next cycle, latch frame_sum=acc, increment frame_cnt (wrapping), clear acc and line_cnt, and stay in LOCKED.
REQ-027 SHALL, in LOCKED on vsync fall with line_cnt != V_TOTAL, set err_vlen, emit no frame_done, leave frame_sum unchanged, clear acc and line_cnt, and stay in LOCKED (relock).
REQ-028 SHALL give an error precedence over frame completion when an h error and a vsync fall coincide: set the error, go to SEARCH, emit no frame_done.
REQ-029 SHALL clear all three error flags when err_clr=1; a flag being set in the same cycle wins over err_clr.
REQ-030 SHALL drive locked from the registered state, i.e. high the cycle after entering LOCKED.

Reset
REQ-031 SHALL, while resetn=0 (asynchronously), hold state=SEARCH; locked, frame_done and all error flags =0; frame_sum, frame_cnt, acc, h_pos, v_pos and line_cnt =0; hs_q and vs_q =1.
REQ-032 SHALL, after resetn deasserts mid-frame, require a vsync fall before any check or frame_done.

Verification
REQ-033 SHALL cover: ideal 800x525 timing, RGB=12'h00F -> locked at first vsync fall; one frame later frame_done, frame_sum=16'h5000, frame_cnt=1.
REQ-034 SHALL cover: ideal timing, RGB=12'hFF0 (307200*4080 mod 2^16) -> frame_sum=16'h0000, frame_done still pulses.
REQ-035 SHALL cover: one line 799 clocks mid-frame -> err_hlen=1, locked=0, no frame_done; relock at next vsync fall; the following full frame gives frame_done.
REQ-036 SHALL cover: hsync low 95 clocks -> err_hsync=1 and SEARCH; err_clr pulse -> flag 0; if err_clr coincides with a new error -> flag stays 1.
REQ-037 SHALL cover: frame of 524 lines -> err_vlen=1, no frame_done, locked stays 1, frame_sum unchanged; next 525-line frame -> frame_done.
REQ-038 SHALL cover: resetn low mid-frame -> all outputs 0 immediately without a clock edge; after release, no frame_done until two vsync falls.

Source files
------------

// File: rtl/vga_frame_checker.sv
// vga_frame_checker: locks onto a VGA stream, checks line/sync/frame
// timing and produces a per-frame checksum of the active RGB pixels.
module vga_frame_checker #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_ACT_S = 144,
  parameter int V_TOTAL = 525,
  parameter int V_ACT_S = 35
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_cnt,
  output logic        err_hlen,
  output logic        err_hsync,
  output logic        err_vlen
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SW    = 11'(H_SYNC);
  localparam logic [10:0] HA_S    = 11'(H_ACT_S);
  localparam logic [10:0] HA_E    = 11'(H_ACT_S + 639);
  localparam logic [10:0] VA_S    = 11'(V_ACT_S);
  localparam logic [10:0] VA_E    = 11'(V_ACT_S + 479);
  localparam logic [10:0] V_LINES = 11'(V_TOTAL);
  localparam logic [9:0]  POS_MAX = 10'd1023;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        hs_q;
  logic        vs_q;
  logic        hs_fall;
  logic        hs_rise;
  logic        vs_fall;
  logic [9:0]  h_q;
  logic [9:0]  v_q;
  logic [9:0]  h_cur;
  logic [9:0]  v_cur;
  logic [9:0]  line_cnt;
  logic [10:0] line_eff;
  logic [15:0] acc;
  logic        first_h;
  logic        active;
  logic        hlen_bad;
  logic        hsync_bad;
  logic        vlen_bad;
  logic        frame_ok;
  logic        restart;

  assign hs_fall = hs_q & ~hsync;
  assign hs_rise = ~hs_q & hsync;
  assign vs_fall = vs_q & ~vsync;

  // h_cur/v_cur are the positions of the pixel sampled this cycle
  assign h_cur = hs_fall ? 10'd0 :
                 (h_q == POS_MAX) ? POS_MAX : h_q + 10'd1;
  assign v_cur = vs_fall ? 10'd0 :
                 !hs_fall ? v_q :
                 (v_q == POS_MAX) ? POS_MAX : v_q + 10'd1;

  // the hsync fall that coincides with vsync fall closes the frame
  assign line_eff = {1'b0, line_cnt} + {10'd0, hs_fall};

  assign active = ({1'b0, h_cur} >= HA_S) && ({1'b0, h_cur} <= HA_E) &&
                  ({1'b0, v_cur} >= VA_S) && ({1'b0, v_cur} <= VA_E);

  assign locked = (state == LOCKED);

  // sync edge-detect registers, idle-high after reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
    end
  end

  // pixel/line position and lines-since-vsync counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q      <= '0;
      v_q      <= '0;
      line_cnt <= '0;
    end else begin
      h_q <= h_cur;
      v_q <= v_cur;
      if (vs_fall) begin
        line_cnt <= '0;
      end else if (hs_fall && line_cnt != POS_MAX) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  // next state and per-cycle check results; h errors beat frame end
  always_comb begin
    state_nx  = state;
    hlen_bad  = 1'b0;
    hsync_bad = 1'b0;
    vlen_bad  = 1'b0;
    frame_ok  = 1'b0;
    restart   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nx = LOCKED;
          restart  = 1'b1;
        end
      end
      LOCKED: begin
        hlen_bad  = hs_fall && !first_h && ({1'b0, h_q} != H_LAST);
        hsync_bad = hs_rise && ({1'b0, h_cur} != H_SW);
        if (hlen_bad || hsync_bad) begin
          state_nx = SEARCH;
        end else if (vs_fall) begin
          restart = 1'b1;
          if (line_eff == V_LINES) begin
            frame_ok = 1'b1;
          end else begin
            vlen_bad = 1'b1;
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // first hsync fall after a fresh lock has no valid previous line
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      first_h <= 1'b0;
    end else if (state == SEARCH && vs_fall) begin
      first_h <= 1'b1;
    end else if (hs_fall) begin
      first_h <= 1'b0;
    end
  end

  // checksum of active pixels while locked
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (restart) begin
      acc <= '0;
    end else if (locked && active) begin
      acc <= acc + {4'd0, R, G, B};
    end
  end

  // frame completion outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_done <= 1'b0;
      frame_sum  <= '0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= frame_ok;
      if (frame_ok) begin
        frame_sum <= acc;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // sticky error flags; a new error wins over err_clr
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_hlen  <= 1'b0;
      err_hsync <= 1'b0;
      err_vlen  <= 1'b0;
    end else begin
      err_hlen  <= hlen_bad  | (err_hlen  & ~err_clr);
      err_hsync <= hsync_bad | (err_hsync & ~err_clr);
      err_vlen  <= vlen_bad  | (err_vlen  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker: drives short-timing VGA frames and scores
// frame_done/frame_sum/frame_cnt against a pixel-level checksum model.
module tb_vga_frame_checker;

  localparam int HT = 40;
  localparam int HS = 4;
  localparam int HA = 10;
  localparam int VT = 12;
  localparam int VA = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        err_clr = 1'b0;
  logic [3:0]  R = '0;
  logic [3:0]  G = '0;
  logic [3:0]  B = '0;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [15:0] frame_cnt;
  logic        err_hlen;
  logic        err_hsync;
  logic        err_vlen;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic [15:0] exp_acc = '0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] last_sum = '0;
  int          cur_h = 0;
  int          cur_v = 0;
  bit          m_hs = 1'b1;
  bit          m_vs = 1'b1;
  int          rgb_fix = -1;

  vga_frame_checker #(
    .H_TOTAL(HT),
    .H_SYNC (HS),
    .H_ACT_S(HA),
    .V_TOTAL(VT),
    .V_ACT_S(VA)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .hsync     (hsync),
    .vsync     (vsync),
    .R         (R),
    .G         (G),
    .B         (B),
    .err_clr   (err_clr),
    .locked    (locked),
    .frame_done(frame_done),
    .frame_sum (frame_sum),
    .frame_cnt (frame_cnt),
    .err_hlen  (err_hlen),
    .err_hsync (err_hsync),
    .err_vlen  (err_vlen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // scoreboard: every frame_done must match the oldest expected frame
  always @(negedge clk) begin
    if (resetn && frame_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(frame_done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_sum", 32'(frame_sum), 32'(mon_e[15:0]));
        chk("frame_cnt", 32'(frame_cnt), 32'(mon_e[31:16]));
      end
    end
  end

  task automatic pixel(input bit hs, input bit vs, input bit clr);
    logic [11:0] rgb;
    bit hf;
    bit vf;
    @(negedge clk);
    rgb = (rgb_fix < 0) ? 12'($urandom) : 12'(rgb_fix);
    hsync = hs;
    vsync = vs;
    err_clr = clr;
    {R, G, B} = rgb;
    hf = m_hs && !hs;
    vf = m_vs && !vs;
    m_hs = hs;
    m_vs = vs;
    cur_h = hf ? 0 : ((cur_h == 1023) ? 1023 : cur_h + 1);
    cur_v = vf ? 0 : (!hf ? cur_v : ((cur_v == 1023) ? 1023 : cur_v + 1));
    if (!vf && cur_h >= HA && cur_h <= HA + 639 &&
        cur_v >= VA && cur_v <= VA + 479)
      exp_acc = exp_acc + 16'(rgb);
  endtask

  task automatic line(input int len, input int sw, input bit vs,
                      input int clr_p);
    for (int p = 0; p < len; p++) pixel(p >= sw, vs, p == clr_p);
  endtask

  // frame: vsync low on lines 0-1; one line may be altered/clear-pulsed
  task automatic frame(input int nl, input int bad_l, input int bad_len,
                       input int bad_sw, input int clr_p,
                       input bit done_prev);
    if (done_prev) begin
      exp_cnt++;
      last_sum = exp_acc;
      exp_q.push_back({exp_cnt, exp_acc});
    end
    exp_acc = '0;
    for (int l = 0; l < nl; l++) begin
      if (l == bad_l) line(bad_len, bad_sw, l >= 2, clr_p);
      else line(HT, HS, l >= 2, -1);
      if (l == 0) begin
        chk("lock", 32'(locked), 32'd1);
        chk("done_seen", 32'(exp_q.size()), 32'd0);
      end
    end
  endtask

  initial begin
    #1;
    chk("rst_flags", 32'({locked, frame_done, err_hlen, err_hsync, err_vlen}),
        32'd0);
    chk("rst_sum", 32'(frame_sum), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    line(HT, HS, 1'b1, -1);
    line(HT, HS, 1'b1, -1);
    chk("search", 32'(locked), 32'd0);

    rgb_fix = 12'h00F;
    frame(VT, -1, 0, 0, -1, 1'b0);
    frame(VT, -1, 0, 0, -1, 1'b1);
    rgb_fix = 12'hFF0;
    frame(VT, -1, 0, 0, -1, 1'b1);
    rgb_fix = -1;
    frame(VT, -1, 0, 0, -1, 1'b1);

    frame(VT, 5, HT - 1, HS, -1, 1'b1);
    chk("hlen_err", 32'(err_hlen), 32'd1);
    chk("hlen_unlock", 32'(locked), 32'd0);
    frame(VT, 2, HT, HS, 7, 1'b0);
    chk("hlen_clr", 32'(err_hlen), 32'd0);

    frame(VT, 4, HT, HS - 1, -1, 1'b1);
    chk("hsync_err", 32'(err_hsync), 32'd1);
    chk("hsync_unlock", 32'(locked), 32'd0);
    frame(VT, 2, HT, HS, 7, 1'b0);
    chk("hsync_clr", 32'(err_hsync), 32'd0);
    frame(VT, 4, HT, HS - 1, HS - 1, 1'b1);
    chk("set_beats_clr", 32'(err_hsync), 32'd1);
    frame(VT, 2, HT, HS, 7, 1'b0);
    chk("hsync_clr2", 32'(err_hsync), 32'd0);

    frame(VT - 1, -1, 0, 0, -1, 1'b1);
    frame(VT, -1, 0, 0, -1, 1'b0);
    chk("vlen_err", 32'(err_vlen), 32'd1);
    chk("vlen_locked", 32'(locked), 32'd1);
    chk("vlen_sum_kept", 32'(frame_sum), 32'(last_sum));
    frame(VT, -1, 0, 0, -1, 1'b1);

    frame(6, -1, 0, 0, -1, 1'b1);
    line(HT / 2, HS, 1'b1, -1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("arst_flags", 32'({locked, frame_done, err_hlen, err_hsync, err_vlen}),
        32'd0);
    chk("arst_sum", 32'(frame_sum), 32'd0);
    chk("arst_cnt", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    m_hs = 1'b1;
    m_vs = 1'b1;
    cur_h = 0;
    cur_v = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) line(HT, HS, 1'b1, -1);
    frame(VT, -1, 0, 0, -1, 1'b0);
    chk("no_done_1st", 32'(frame_cnt), 32'd0);
    frame(VT, -1, 0, 0, -1, 1'b1);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd1);
    chk("final_flags", 32'({err_hlen, err_hsync, err_vlen}), 32'd0);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
